laser_burst_ctrl: RTL and testbench

- Parametrised successor to the fixed 16-cycle laser controller.
- Fires a burst of NPulses laser pulses. Each pulse is OnTime cycles on, and pulses are separated by OffTime cycles off.
- After the burst, a mandatory cooldown lockout runs before the next start is accepted.
- Sits between the operator button/interlock logic and the laser driver. It contains its own FSM and countdown timer datapath.

---
 rtl/laser_burst_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_laser_burst_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_burst_ctrl.sv
// Burst laser pulse controller: NPulses pulses of OnTime cycles separated by OffTime gaps, then a cooldown lockout.
// Optional macro LASER_INTERLOCK_EN adds the Interlock input and the sticky Fault output.
module laser_burst_ctrl #(
    parameter int NBits      = 8,
    parameter int NPulseBits = 4,
    parameter int COOLDOWN   = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  B,
    input  logic                  Abort,
    input  logic [NBits-1:0]      OnTime,
    input  logic [NBits-1:0]      OffTime,
    input  logic [NPulseBits-1:0] NPulses,
`ifdef LASER_INTERLOCK_EN
    input  logic                  Interlock,
    output logic                  Fault,
`endif
    output logic                  X,
    output logic                  Busy,
    output logic                  Done,
    output logic [NPulseBits-1:0] PulseCnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_COOL = 2'd3
    } state_t;

    localparam logic [NBits-1:0]      T_ZERO    = {NBits{1'b0}};
    localparam logic [NBits-1:0]      T_ONE     = {{(NBits-1){1'b0}}, 1'b1};
    localparam logic [NBits-1:0]      COOL_LOAD = NBits'(COOLDOWN - 1);
    localparam logic [NPulseBits-1:0] P_ZERO    = {NPulseBits{1'b0}};
    localparam logic [NPulseBits-1:0] P_ONE     = {{(NPulseBits-1){1'b0}}, 1'b1};

    state_t                  state_r, state_s;
    logic [NBits-1:0]        timer_r, timer_s;
    logic [NBits-1:0]        on_r, on_s;
    logic [NBits-1:0]        off_r, off_s;
    logic [NPulseBits-1:0]   np_r, np_s;
    logic [NPulseBits-1:0]   pcnt_r, pcnt_s;
    logic                    aborted_r, aborted_s;
    logic                    done_r, done_s;
    logic                    x_r;
    logic                    busy_r;
    logic                    b_q_r;

    logic                    safe_s;
    logic                    stop_s;
    logic                    start_s;
    logic                    ops_valid_s;
    logic [NBits-1:0]        off_eff_s;
    logic [NPulseBits-1:0]   pcnt_inc_s;
    logic                    last_s;

`ifdef LASER_INTERLOCK_EN
    logic                    fault_r;
    assign safe_s = Interlock;
`else
    assign safe_s = 1'b1;
`endif

    // A dropped interlock behaves exactly like Abort and also blocks starts.
    assign stop_s      = Abort | ~safe_s;
    assign start_s     = B & ~b_q_r;
    assign ops_valid_s = (OnTime != T_ZERO) && (NPulses != P_ZERO);
    assign off_eff_s   = (OffTime == T_ZERO) ? T_ONE : OffTime;
    assign pcnt_inc_s  = (pcnt_r < np_r) ? (pcnt_r + P_ONE) : pcnt_r;
    assign last_s      = (pcnt_inc_s == np_r);

    // Next-state and datapath update for the burst sequencer
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        on_s      = on_r;
        off_s     = off_r;
        np_s      = np_r;
        pcnt_s    = pcnt_r;
        aborted_s = aborted_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s && !stop_s && ops_valid_s) begin
                    state_s   = ST_ON;
                    timer_s   = OnTime - T_ONE;
                    on_s      = OnTime;
                    off_s     = off_eff_s;
                    np_s      = NPulses;
                    pcnt_s    = P_ZERO;
                    aborted_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ON: begin
                if (stop_s) begin
                    state_s   = ST_COOL;
                    timer_s   = COOL_LOAD;
                    aborted_s = 1'b1;
                end else if (timer_r == T_ZERO) begin
                    pcnt_s = pcnt_inc_s;
                    if (last_s) begin
                        state_s = ST_COOL;
                        timer_s = COOL_LOAD;
                    end else begin
                        state_s = ST_OFF;
                        timer_s = off_r - T_ONE;
                    end
                end else begin
                    timer_s = timer_r - T_ONE;
                end
            end
            ST_OFF: begin
                if (stop_s) begin
                    state_s   = ST_COOL;
                    timer_s   = COOL_LOAD;
                    aborted_s = 1'b1;
                end else if (timer_r == T_ZERO) begin
                    state_s = ST_ON;
                    timer_s = on_r - T_ONE;
                end else begin
                    timer_s = timer_r - T_ONE;
                end
            end
            ST_COOL: begin
                // Cooldown ignores Abort so the lockout can never be shortened.
                if (timer_r == T_ZERO) begin
                    state_s = ST_IDLE;
                    done_s  = ~aborted_r;
                end else begin
                    timer_s = timer_r - T_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = T_ZERO;
            end
        endcase
    end

    // State, datapath and registered Moore outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= T_ZERO;
            on_r      <= T_ZERO;
            off_r     <= T_ZERO;
            np_r      <= P_ZERO;
            pcnt_r    <= P_ZERO;
            aborted_r <= 1'b0;
            done_r    <= 1'b0;
            x_r       <= 1'b0;
            busy_r    <= 1'b0;
            b_q_r     <= 1'b1;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            on_r      <= on_s;
            off_r     <= off_s;
            np_r      <= np_s;
            pcnt_r    <= pcnt_s;
            aborted_r <= aborted_s;
            done_r    <= done_s;
            x_r       <= (state_s == ST_ON);
            busy_r    <= (state_s != ST_IDLE);
            b_q_r     <= B;
        end
    end

`ifdef LASER_INTERLOCK_EN
    // Sticky fault: interlock lost while a burst or cooldown was in progress
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_r | (busy_r & ~Interlock);
        end
    end

    assign Fault = fault_r;
    assign X     = x_r & Interlock;
`else
    assign X     = x_r;
`endif

    assign Busy     = busy_r;
    assign Done     = done_r;
    assign PulseCnt = pcnt_r;

endmodule

// File: tb/tb_laser_burst_ctrl.sv
// Self-checking bench for laser_burst_ctrl: burst table, directed corner sequences and random stimulus vs a reference model.
module tb_laser_burst_ctrl;

    localparam int NB  = 8;
    localparam int NPB = 4;
    localparam int CD  = 32;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           B;
    logic           Abort;
    logic [NB-1:0]  OnTime;
    logic [NB-1:0]  OffTime;
    logic [NPB-1:0] NPulses;
    logic           X;
    logic           Busy;
    logic           Done;
    logic [NPB-1:0] PulseCnt;
    logic           Interlock = 1'b1;
    logic           Fault;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: burst described by position inside the pulse train or cooldown count
    int m_mode = 0;     // 0 idle, 1 pulse train, 2 cooldown
    int m_pos  = 0;
    int m_cool = 0;
    int m_on   = 0;
    int m_off  = 1;
    int m_np   = 0;
    int m_pc   = 0;
    bit m_abrt = 1'b0;
    bit m_done = 1'b0;
    bit m_bq   = 1'b1;
    bit model_en = 1'b1;

    typedef struct {
        int on;
        int off;
        int np;
        int abort_at;
        int xh;
        int busy;
        int done;
        int pc;
    } vec_t;

    vec_t tbl[7];

    always #5 Clk = ~Clk;

    laser_burst_ctrl #(.NBits(NB), .NPulseBits(NPB), .COOLDOWN(CD)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .B        (B),
        .Abort    (Abort),
        .OnTime   (OnTime),
        .OffTime  (OffTime),
        .NPulses  (NPulses),
`ifdef LASER_INTERLOCK_EN
        .Interlock(Interlock),
        .Fault    (Fault),
`endif
        .X        (X),
        .Busy     (Busy),
        .Done     (Done),
        .PulseCnt (PulseCnt)
    );

`ifndef LASER_INTERLOCK_EN
    assign Fault = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int completed(input int pos);
        int per;
        int c;
        per = m_on + m_off;
        c = pos / per + (((pos % per) >= m_on) ? 1 : 0);
        return (c > m_np) ? m_np : c;
    endfunction

    function automatic void model_step(input bit r, input bit b, input bit ab,
                                       input int on, input int off, input int np);
        bit start;
        m_done = 1'b0;
        if (r) begin
            m_mode = 0;
            m_pc   = 0;
            m_bq   = 1'b1;
        end else begin
            start = b && !m_bq;
            m_bq  = b;
            if (m_mode == 0) begin
                if (start && !ab && on != 0 && np != 0) begin
                    m_mode = 1;
                    m_pos  = 0;
                    m_on   = on;
                    m_off  = (off == 0) ? 1 : off;
                    m_np   = np;
                    m_pc   = 0;
                end
            end else if (m_mode == 1) begin
                if (ab) begin
                    m_mode = 2;
                    m_cool = CD;
                    m_abrt = 1'b1;
                end else begin
                    m_pos++;
                    m_pc = completed(m_pos);
                    if (m_pos == m_np * m_on + (m_np - 1) * m_off) begin
                        m_mode = 2;
                        m_cool = CD;
                        m_abrt = 1'b0;
                    end
                end
            end else begin
                m_cool--;
                if (m_cool == 0) begin
                    m_mode = 0;
                    m_done = !m_abrt;
                end
            end
        end
    endfunction

    // One clock: capture the applied inputs, advance the model, compare after the edge
    task automatic step();
        bit r, b, a;
        int on, off, np;
        int ex;
        r = Rst; b = B; a = Abort;
        on = OnTime; off = OffTime; np = NPulses;
        @(posedge Clk);
        model_step(r, b, a, on, off, np);
        #1;
        if (model_en) begin
            ex = (m_mode == 1 && (m_pos % (m_on + m_off)) < m_on) ? 1 : 0;
            check("model_X", int'(X), ex);
            check("model_Busy", int'(Busy), (m_mode != 0) ? 1 : 0);
            check("model_Done", int'(Done), int'(m_done));
            check("model_PulseCnt", int'(PulseCnt), m_pc);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1; B = 1'b0; Abort = 1'b0;
        step();
        Rst = 1'b0;
        step();
    endtask

    task automatic run_entry(input vec_t t);
        int xh, bc, dc;
        do_reset();
        OnTime = NB'(t.on); OffTime = NB'(t.off); NPulses = NPB'(t.np);
        B = 1'b1;
        step();
        xh = int'(X); bc = int'(Busy); dc = int'(Done);
        for (int n = 1; n <= t.busy + 5; n++) begin
            Abort = (n == t.abort_at);
            B = (n <= 30) ? n[1] : 1'b0;
            if (t.busy != 0) begin
                OnTime = NB'($urandom); OffTime = NB'($urandom); NPulses = NPB'($urandom);
            end
            step();
            xh += int'(X); bc += int'(Busy); dc += int'(Done);
        end
        Abort = 1'b0;
        check("tbl_xhigh", xh, t.xh);
        check("tbl_busy", bc, t.busy);
        check("tbl_done", dc, t.done);
        check("tbl_pcnt", int'(PulseCnt), t.pc);
    endtask

    initial begin
        logic [17:0] pat;
        Rst = 1'b1; B = 1'b0; Abort = 1'b0;
        OnTime = '0; OffTime = '0; NPulses = '0;

        // Reset state
        step();
        check("reset_X", int'(X), 0);
        check("reset_Busy", int'(Busy), 0);
        check("reset_PulseCnt", int'(PulseCnt), 0);
        Rst = 1'b0;
        step();

        tbl[0] = '{on:16,  off:0,   np:1,  abort_at:-1, xh:16,   busy:48,   done:1, pc:1};
        tbl[1] = '{on:3,   off:2,   np:4,  abort_at:-1, xh:12,   busy:50,   done:1, pc:4};
        tbl[2] = '{on:2,   off:0,   np:2,  abort_at:-1, xh:4,    busy:37,   done:1, pc:2};
        tbl[3] = '{on:3,   off:2,   np:5,  abort_at:7,  xh:5,    busy:39,   done:0, pc:1};
        tbl[4] = '{on:0,   off:3,   np:3,  abort_at:-1, xh:0,    busy:0,    done:0, pc:0};
        tbl[5] = '{on:5,   off:1,   np:0,  abort_at:-1, xh:0,    busy:0,    done:0, pc:0};
        tbl[6] = '{on:255, off:255, np:15, abort_at:-1, xh:3825, busy:7427, done:1, pc:15};
        for (int i = 0; i < 7; i++) begin
            run_entry(tbl[i]);
        end

        // Exact X pattern including the zero-latency first edge
        do_reset();
        pat = 18'b111_00_111_00_111_00_111;
        OnTime = 8'd3; OffTime = 8'd2; NPulses = 4'd4; B = 1'b1;
        for (int i = 0; i < 51; i++) begin
            step();
            if (i < 18) check("pattern_X", int'(X), int'(pat[17 - i]));
            else if (i < 50) check("cool_X", int'(X), 0);
            else check("final_Done", int'(Done), 1);
        end
        check("final_PulseCnt", int'(PulseCnt), 4);
        B = 1'b0;
        step();

        // Button held through reset release never fires
        Rst = 1'b1; B = 1'b1; OnTime = 8'd5; NPulses = 4'd1;
        step();
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("held_B_Busy", int'(Busy), 0);
        end
        B = 1'b0;
        step();
        B = 1'b1;
        step();
        check("fresh_edge_X", int'(X), 1);
        for (int i = 0; i < 40; i++) step();

        // Reset in the middle of the second pulse
        do_reset();
        OnTime = 8'd3; OffTime = 8'd1; NPulses = 4'd3; B = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_PulseCnt", int'(PulseCnt), 1);
        Rst = 1'b1;
        step();
        check("midrst_X", int'(X), 0);
        check("midrst_Busy", int'(Busy), 0);
        check("midrst_PulseCnt", int'(PulseCnt), 0);
        Rst = 1'b0; B = 1'b0;
        step();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            Rst     = ($urandom_range(299) == 0);
            B       = ($urandom_range(2) == 0);
            Abort   = ($urandom_range(39) == 0);
            OnTime  = NB'($urandom_range(4));
            OffTime = NB'($urandom_range(3));
            NPulses = NPB'($urandom_range(4));
            step();
        end

`ifdef LASER_INTERLOCK_EN
        model_en = 1'b0;
        do_reset();
        OnTime = 8'd10; OffTime = 8'd1; NPulses = 4'd1; B = 1'b1;
        step();
        step();
        Interlock = 1'b0;
        #1;
        check("ilk_X_same_cycle", int'(X), 0);
        step();
        check("ilk_Busy_cool", int'(Busy), 1);
        check("ilk_Fault", int'(Fault), 1);
        B = 1'b0;
        for (int i = 0; i < 40; i++) step();
        B = 1'b1;
        step();
        check("ilk_start_blocked", int'(Busy), 0);
        check("ilk_Fault_sticky", int'(Fault), 1);
        Rst = 1'b1; B = 1'b0;
        step();
        check("ilk_Fault_cleared", int'(Fault), 0);
        Interlock = 1'b1; Rst = 1'b0;
        model_en = 1'b1;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
